// File: rtl/scope_readout.sv
// Capture-buffer reader: records DEPTH ADC bytes into block RAM, then dumps a
// sync header followed by the buffer over a back-to-back UART 8N1 stream.
module scope_readout #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          ADDR_W       = 10,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iStart,
    input  logic       iSampleValid,
    input  logic [7:0] iSample,
    output logic       oTX,
    output logic       oBusy,
    output logic       oDone
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};
    localparam logic [3:0]        BIT_LAST_DATA = 4'd8;
    localparam logic [3:0]        BIT_STOP  = 4'd9;

    // state     | meaning
    // IDLE      | line high, waiting for iStart
    // CAPTURE   | writing valid samples into the buffer
    // SEND_HDR  | transmitting the sync header frame
    // SEND_DATA | transmitting buffer[0..DEPTH-1]
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        SEND_HDR  = 2'd2,
        SEND_DATA = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [BAUD_W-1:0]   baud_q,   baud_d;
    logic [3:0]          bit_q,    bit_d;
    logic [7:0]          shift_q,  shift_d;
    logic                tx_q,     tx_d;
    logic                done_q,   done_d;
    logic                wr_en;
    logic                bit_end;

    logic [7:0]          buf_mem [DEPTH];
    logic [7:0]          rd_data_q;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (iStart) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                end
            end

            CAPTURE: begin
                if (iSampleValid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == PTR_LAST) begin
                        // Header start bit goes out on the same edge as the last write.
                        state_d  = SEND_HDR;
                        rd_ptr_d = '0;
                        shift_d  = HEADER;
                        tx_d     = 1'b0;
                        baud_d   = '0;
                        bit_d    = '0;
                    end
                end
            end

            SEND_HDR, SEND_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_STOP) begin
                        bit_d = '0;
                        // rd_ptr wraps to 0 once the last byte has been loaded.
                        if (state_q == SEND_DATA && rd_ptr_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            tx_d    = 1'b1;
                        end else begin
                            state_d  = SEND_DATA;
                            shift_d  = rd_data_q;
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            tx_d     = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q == BIT_LAST_DATA) begin
                            tx_d = 1'b1;
                        end else begin
                            tx_d    = shift_q[0];
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    // Buffer is left uncleared by reset so it maps onto block RAM.
    always_ff @(posedge iCLK) begin
        if (wr_en && !iRST) begin
            buf_mem[wr_ptr_q] <= iSample;
        end
        rd_data_q <= buf_mem[rd_ptr_q];
    end

    assign oTX   = tx_q;
    assign oDone = done_q;
    assign oBusy = (state_q != IDLE);

endmodule

// File: doc/scope_readout.md
# scope_readout

Capture-buffer reader for the ice40 scope. It records one block of ADC samples into an internal on-chip buffer, then streams the block out over a UART 8N1 serial line to the host. It is the readout end of the ADC sample path: the scope front end supplies sample bytes with a valid strobe, and this block turns them into a framed serial dump.

## Interface

Parameters:
- CLKS_PER_BIT, default 868: clock cycles per UART bit. 100 MHz / 115200 baud. Legal range ≥ 2.
- ADDR_W, default 10: buffer address width. DEPTH = 2^ADDR_W samples per capture.
- HEADER, default 8'hA5: sync byte sent before the sample data.

Ports:
- iCLK, input, 1: system clock, 100 MHz. All logic is on the rising edge.
- iRST, input, 1: reset. Synchronous, active-high.
- iStart, input, 1: single-cycle request to begin a capture. Honoured only in IDLE.
- iSampleValid, input, 1: iSample carries a new ADC byte this cycle.
- iSample, input, 8: ADC sample byte.
- oTX, output, 1: UART transmit line. Idle level is high.
- oBusy, output, 1: high in every state except IDLE.
- oDone, output, 1: one-cycle pulse when the final stop bit of a dump completes.

## Operation

- FSM states: IDLE, CAPTURE, SEND_HDR, SEND_DATA.
- **IDLE:**
  - oTX=1, oBusy=0.
  - iStart=1 → CAPTURE, and the write pointer clears to 0.
  - iSampleValid is ignored.
- **CAPTURE:**
  - Each cycle with iSampleValid=1, iSample is written at the write pointer, and the pointer increments.
  - iSampleValid=0 cycles are skipped. Capture has no timeout.
  - The DEPTH-th write → SEND_HDR on the next cycle. The pointer wraps to 0; no sample beyond DEPTH is stored.
- **SEND_HDR:**
  - Transmits HEADER as one frame, then → SEND_DATA with read pointer 0.
- **SEND_DATA:**
  - Transmits buffer[0] … buffer[DEPTH-1] in address order, one frame each.
  - After the stop bit of buffer[DEPTH-1] → IDLE, with oDone=1 for that one cycle.
- **UART frame:**
  - One start bit (0), eight data bits LSB first, one stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Frames are back-to-back: the next start bit begins the cycle after the previous stop bit ends. There are no idle bits between header and data, or between data bytes.
- **Buffer:**
  - Single-port-per-direction RAM that infers iCE40 block RAM, with 1-cycle registered read latency.
  - The next byte is prefetched during the current frame, so no gap is introduced.
- **Ignored inputs:**
  - iStart in any state other than IDLE is ignored. No queuing.
  - iSampleValid outside CAPTURE is ignored. Buffer contents are not modified.
- **Reset:**
  - iRST=1 at any point, including mid-capture or mid-frame, forces the following on the next edge: state IDLE, oTX=1, oBusy=0, oDone=0, pointers 0, bit and baud counters 0.
  - Buffer contents are not cleared.
  - A partially sent frame is truncated, and the line returns high immediately.
  - iRST takes priority over iStart in the same cycle.

## Timing

- **Reset values:** oTX=1, oBusy=0, oDone=0.
- **Start:**
  - iStart sampled high at edge t → oBusy=1 from t+1.
  - The first sample accepted is at t+1 at the earliest.
- **Capture to transmit:**
  - Final capture write at edge k → oTX=0 (header start bit) from k+1.
- **Frame length:** 10·CLKS_PER_BIT cycles.
- **Dump length:** (DEPTH+1)·10·CLKS_PER_BIT cycles, from k+1 through k+(DEPTH+1)·10·CLKS_PER_BIT.
- **Completion:**
  - oDone=1 and oBusy=0 at cycle k+(DEPTH+1)·10·CLKS_PER_BIT+1.
  - iStart in that same cycle is accepted, because the state is already IDLE.
- **oTX glitch-free:** oTX is driven directly from a register with no combinational path.
- **Counter widths:**
  - Baud counter: ceil(log2(CLKS_PER_BIT)) bits.
  - Bit counter: 4 bits.
  - Pointers: ADDR_W bits.
  - All counters wrap modulo their width, and wrap is never relied on mid-frame.

## Test plan

All scenarios use ADDR_W=2 (DEPTH 4) and CLKS_PER_BIT=4.

1. **Basic dump.** Reset; pulse iStart; drive iSample 0x01, 0x80, 0xFF, 0x3C on four consecutive valid cycles (last at k).
   - oTX start bit at k+1.
   - Decoded bytes are A5, 01, 80, FF, 3C.
   - Each bit lasts 4 cycles, with no gaps.
   - oDone pulse at k+201; oBusy falls at k+201.
2. **Sparse valid.** Same data with iSampleValid gaps of 0–7 cycles.
   - Identical serial output, starting one cycle after the 4th valid.
   - Gap cycles do not write.
3. **Ignored inputs.** Pulse iStart during CAPTURE and during SEND_DATA; drive iSampleValid during SEND_DATA.
   - No restart.
   - Transmitted bytes are unchanged.
   - Total length is still 200 cycles.
4. **Reset mid-frame.** Assert iRST during data bit 3 of the second byte.
   - Next cycle: oTX=1, oBusy=0, oDone=0.
   - A new iStart with samples 0x55 ×4 gives A5, 55, 55, 55, 55.
5. **Back-to-back captures.** Assert iStart in the oDone cycle.
   - oBusy rises the next cycle.
   - The second dump is correct with the new data.
6. **Idle line.** After reset with no iStart for 1000 cycles.
   - oTX=1 constantly; oBusy=0; oDone never pulses.
